// File: rtl/counter_bank.sv
// counter_bank: NCH up/down counters sharing one run-time limit and wrap/saturate mode.
module counter_bank #(
  parameter int WIDTH = 8,
  parameter int NCH = 4,
  parameter int DEFAULT_LIMIT = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_we,
  input  logic [WIDTH-1:0]     cfg_limit,
  input  logic                 cfg_sat,
  input  logic [NCH-1:0]       clr,
  input  logic [NCH-1:0]       inc,
  input  logic [NCH-1:0]       dec,
  output logic [NCH*WIDTH-1:0] count,
  output logic [NCH-1:0]       at_limit,
  output logic [NCH-1:0]       wrap,
  output logic [WIDTH-1:0]     limit,
  output logic                 sat_mode
);
  logic [NCH-1:0][WIDTH-1:0] cnt_q, cnt_d;
  logic [NCH-1:0] wrap_q, wrap_d, up, dn;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic sat_q, sat_d;
  assign up = inc & ~dec;
  assign dn = dec & ~inc;
  always_comb begin
    limit_d = cfg_we ? cfg_limit : limit_q;
    sat_d = cfg_we ? cfg_sat : sat_q;
    for (int i = 0; i < NCH; i++) begin
      cnt_d[i] = cnt_q[i];
      wrap_d[i] = 1'b0;
      if (clr[i]) cnt_d[i] = '0;
      else if (cfg_we) cnt_d[i] = cnt_q[i] > cfg_limit ? cfg_limit : cnt_q[i];
      else if (up[i]) begin
        // compare before adding so limit = all-ones never overflows
        cnt_d[i] = cnt_q[i] < limit_q ? cnt_q[i] + WIDTH'(1) : sat_q ? cnt_q[i] : '0;
        wrap_d[i] = cnt_q[i] >= limit_q && !sat_q;
      end else if (dn[i]) begin
        cnt_d[i] = cnt_q[i] != '0 ? cnt_q[i] - WIDTH'(1) : sat_q ? cnt_q[i] : limit_q;
        wrap_d[i] = cnt_q[i] == '0 && !sat_q;
      end
      at_limit[i] = cnt_q[i] == limit_q;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      wrap_q <= '0;
      limit_q <= WIDTH'(DEFAULT_LIMIT);
      sat_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      wrap_q <= wrap_d;
      limit_q <= limit_d;
      sat_q <= sat_d;
    end
  end
  assign count = cnt_q;
  assign wrap = wrap_q;
  assign limit = limit_q;
  assign sat_mode = sat_q;
`ifdef FORMAL
  logic [NCH-1:0] quiet_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) quiet_q <= '0;
    else quiet_q <= clr | {NCH{cfg_we}};
  end
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      assert (cnt_q[i] <= limit_q);
      assert (!(quiet_q[i] && wrap_q[i]));
    end
  end
`endif
endmodule

// File: tb/tb_counter_bank.sv
// tb_counter_bank: directed vector table, random run against a rule-level model, and a WIDTH=4 boundary instance.
module tb_counter_bank;
  localparam int W = 8;
  localparam int N = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic cfg_we, cfg_sat;
  logic [W-1:0] cfg_limit, limit;
  logic [N-1:0] clr, inc, dec, at_limit, wrap;
  logic [N*W-1:0] count;
  logic sat_mode;
  logic b_cfg_we, b_cfg_sat, b_clr, b_inc, b_dec, b_at_limit, b_wrap, b_sat_mode;
  logic [3:0] b_cfg_limit, b_count, b_limit;
  counter_bank #(.WIDTH(W), .NCH(N), .DEFAULT_LIMIT(5)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_limit(cfg_limit), .cfg_sat(cfg_sat),
    .clr(clr), .inc(inc), .dec(dec), .count(count), .at_limit(at_limit), .wrap(wrap),
    .limit(limit), .sat_mode(sat_mode)
  );
  counter_bank #(.WIDTH(4), .NCH(1), .DEFAULT_LIMIT(15)) dut4 (
    .clk(clk), .rst_n(rst_n), .cfg_we(b_cfg_we), .cfg_limit(b_cfg_limit), .cfg_sat(b_cfg_sat),
    .clr(b_clr), .inc(b_inc), .dec(b_dec), .count(b_count), .at_limit(b_at_limit), .wrap(b_wrap),
    .limit(b_limit), .sat_mode(b_sat_mode)
  );
  int errs = 0;
  int checks = 0;
  int m_cnt[N];
  int m_lim, m_sat;
  logic [N-1:0] m_wrap;
  typedef struct {
    logic we; logic [7:0] lim; logic sat;
    logic [3:0] c, i, d;
    logic [31:0] ec; logic [3:0] ew; logic [7:0] el; logic es;
  } vec_t;
  vec_t tv[$];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic void add(input logic we, input logic [7:0] lim, input logic sat,
                              input logic [3:0] c, input logic [3:0] i, input logic [3:0] d,
                              input logic [31:0] ec, input logic [3:0] ew, input logic [7:0] el, input logic es);
    vec_t v;
    v.we = we; v.lim = lim; v.sat = sat; v.c = c; v.i = i; v.d = d;
    v.ec = ec; v.ew = ew; v.el = el; v.es = es;
    tv.push_back(v);
  endfunction
  function automatic void model_reset();
    for (int k = 0; k < N; k++) m_cnt[k] = 0;
    m_lim = 5; m_sat = 0; m_wrap = '0;
  endfunction
  // applies the behavioural rules to the inputs currently driven
  function automatic void model_step();
    for (int k = 0; k < N; k++) begin
      m_wrap[k] = 1'b0;
      if (clr[k]) m_cnt[k] = 0;
      else if (cfg_we) m_cnt[k] = m_cnt[k] > int'(cfg_limit) ? int'(cfg_limit) : m_cnt[k];
      else if (inc[k] && !dec[k]) begin
        if (m_cnt[k] < m_lim) m_cnt[k]++;
        else if (m_sat == 0) begin m_cnt[k] = 0; m_wrap[k] = 1'b1; end
      end else if (dec[k] && !inc[k]) begin
        if (m_cnt[k] > 0) m_cnt[k]--;
        else if (m_sat == 0) begin m_cnt[k] = m_lim; m_wrap[k] = 1'b1; end
      end
    end
    if (cfg_we) begin m_lim = int'(cfg_limit); m_sat = int'(cfg_sat); end
  endfunction
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask
  task automatic check_model();
    logic [N*W-1:0] ec;
    logic [N-1:0] ea;
    for (int k = 0; k < N; k++) begin
      ec[k*W +: W] = W'(m_cnt[k]);
      ea[k] = m_cnt[k] == m_lim;
    end
    chk("count", 64'(count), 64'(ec));
    chk("wrap", 64'(wrap), 64'(m_wrap));
    chk("limit", 64'(limit), 64'(m_lim));
    chk("sat_mode", 64'(sat_mode), 64'(m_sat));
    chk("at_limit", 64'(at_limit), 64'(ea));
  endtask
  task automatic idle();
    cfg_we = 0; cfg_limit = '0; cfg_sat = 0; clr = '0; inc = '0; dec = '0;
  endtask
  task automatic b_tick(input string name, input logic [3:0] ec, input logic ew, input logic [3:0] el, input logic ea);
    @(posedge clk);
    #1;
    chk({name, ".count"}, 64'(b_count), 64'(ec));
    chk({name, ".wrap"}, 64'(b_wrap), 64'(ew));
    chk({name, ".limit"}, 64'(b_limit), 64'(el));
    chk({name, ".at_limit"}, 64'(b_at_limit), 64'(ea));
  endtask
  initial begin
    idle();
    b_cfg_we = 0; b_cfg_limit = '0; b_cfg_sat = 0; b_clr = 0; b_inc = 0; b_dec = 0;
    model_reset();
    // wrap increment on ch0 from reset, limit 5
    add(0, 0, 0, 4'h0, 4'h1, 4'h0, 32'h00000001, 4'h0, 5, 0);
    add(0, 0, 0, 4'h0, 4'h1, 4'h0, 32'h00000002, 4'h0, 5, 0);
    add(0, 0, 0, 4'h0, 4'h1, 4'h0, 32'h00000003, 4'h0, 5, 0);
    add(0, 0, 0, 4'h0, 4'h1, 4'h0, 32'h00000004, 4'h0, 5, 0);
    add(0, 0, 0, 4'h0, 4'h1, 4'h0, 32'h00000005, 4'h0, 5, 0);
    add(0, 0, 0, 4'h0, 4'h1, 4'h0, 32'h00000000, 4'h1, 5, 0);
    add(0, 0, 0, 4'h0, 4'h1, 4'h0, 32'h00000001, 4'h0, 5, 0);
    // ch2/ch3 up to 5, then clamp on cfg write with inc ignored
    add(0, 0, 0, 4'h0, 4'hC, 4'h0, 32'h01010001, 4'h0, 5, 0);
    add(0, 0, 0, 4'h0, 4'hC, 4'h0, 32'h02020001, 4'h0, 5, 0);
    add(0, 0, 0, 4'h0, 4'hC, 4'h0, 32'h03030001, 4'h0, 5, 0);
    add(0, 0, 0, 4'h0, 4'hC, 4'h0, 32'h04040001, 4'h0, 5, 0);
    add(0, 0, 0, 4'h0, 4'hC, 4'h0, 32'h05050001, 4'h0, 5, 0);
    add(1, 2, 0, 4'h0, 4'h4, 4'h0, 32'h02020001, 4'h0, 2, 0);
    // clr beats cfg_we and inc; inc+dec holds
    add(1, 4, 0, 4'h8, 4'h8, 4'h0, 32'h00020001, 4'h0, 4, 0);
    add(0, 0, 0, 4'h0, 4'h1, 4'h5, 32'h00010001, 4'h0, 4, 0);
    // saturate mode, limit 3
    add(1, 3, 1, 4'h0, 4'h0, 4'h0, 32'h00010001, 4'h0, 3, 1);
    add(0, 0, 0, 4'h0, 4'h0, 4'h2, 32'h00010001, 4'h0, 3, 1);
    add(0, 0, 0, 4'h0, 4'h2, 4'h0, 32'h00010101, 4'h0, 3, 1);
    add(0, 0, 0, 4'h0, 4'h2, 4'h0, 32'h00010201, 4'h0, 3, 1);
    add(0, 0, 0, 4'h0, 4'h2, 4'h0, 32'h00010301, 4'h0, 3, 1);
    add(0, 0, 0, 4'h0, 4'h2, 4'h0, 32'h00010301, 4'h0, 3, 1);
    add(0, 0, 0, 4'h0, 4'h2, 4'h0, 32'h00010301, 4'h0, 3, 1);
    // back to wrap mode: dec at 0 loads limit and pulses once
    add(1, 3, 0, 4'h0, 4'h0, 4'h0, 32'h00010301, 4'h0, 3, 0);
    add(0, 0, 0, 4'h0, 4'h0, 4'h8, 32'h03010301, 4'h8, 3, 0);
    add(0, 0, 0, 4'h0, 4'h0, 4'h0, 32'h03010301, 4'h0, 3, 0);
    #12;
    chk("rst.count", 64'(count), 64'h0);
    chk("rst.wrap", 64'(wrap), 64'h0);
    chk("rst.limit", 64'(limit), 64'd5);
    chk("rst.sat_mode", 64'(sat_mode), 64'h0);
    chk("rst.at_limit", 64'(at_limit), 64'h0);
    chk("rst.b_limit", 64'(b_limit), 64'd15);
    rst_n = 1'b1;
    foreach (tv[r]) begin
      logic [3:0] ea;
      cfg_we = tv[r].we; cfg_limit = tv[r].lim; cfg_sat = tv[r].sat;
      clr = tv[r].c; inc = tv[r].i; dec = tv[r].d;
      tick();
      for (int k = 0; k < N; k++) ea[k] = tv[r].ec[k*8 +: 8] == tv[r].el;
      chk($sformatf("vec%0d.count", r), 64'(count), 64'(tv[r].ec));
      chk($sformatf("vec%0d.wrap", r), 64'(wrap), 64'(tv[r].ew));
      chk($sformatf("vec%0d.limit", r), 64'(limit), 64'(tv[r].el));
      chk($sformatf("vec%0d.sat", r), 64'(sat_mode), 64'(tv[r].es));
      chk($sformatf("vec%0d.at_limit", r), 64'(at_limit), 64'(ea));
    end
    for (int n = 0; n < 600; n++) begin
      cfg_we = $urandom_range(0, 15) == 0;
      cfg_limit = $urandom_range(0, 3) == 0 ? W'($urandom_range(0, 255)) : W'($urandom_range(0, 6));
      if ($urandom_range(0, 7) == 0) cfg_limit = 8'hFF;
      cfg_sat = 1'($urandom_range(0, 1));
      for (int k = 0; k < N; k++) clr[k] = $urandom_range(0, 9) == 0;
      inc = N'($urandom);
      dec = N'($urandom);
      tick();
      check_model();
    end
    // asynchronous reset between edges, then inc held through reset
    idle(); cfg_we = 1; cfg_limit = 8'd5; tick(); check_model();
    idle(); inc = '1; tick(); check_model();
    inc = 4'h1;
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_model();
    @(posedge clk); #1;
    check_model();
    #3 rst_n = 1'b1;
    tick();
    check_model();
    idle();
    // WIDTH=4 boundary: limit 15 wrap, then limit 0
    b_inc = 1;
    repeat (15) @(posedge clk);
    #1;
    chk("w4.count15", 64'(b_count), 64'd15);
    chk("w4.at15", 64'(b_at_limit), 64'd1);
    b_tick("w4.inc15", 4'd0, 1, 4'd15, 0);
    b_inc = 0; b_dec = 1;
    b_tick("w4.dec0", 4'd15, 1, 4'd15, 1);
    b_dec = 0; b_cfg_we = 1; b_cfg_limit = 4'd0; b_cfg_sat = 0; b_inc = 1;
    b_tick("w4.cfg0", 4'd0, 0, 4'd0, 1);
    b_cfg_we = 0;
    b_tick("w4.inc_lim0", 4'd0, 1, 4'd0, 1);
    b_inc = 0; b_dec = 1;
    b_tick("w4.dec_lim0", 4'd0, 1, 4'd0, 1);
    b_dec = 0; b_cfg_we = 1; b_cfg_sat = 1;
    b_tick("w4.cfgsat", 4'd0, 0, 4'd0, 1);
    b_cfg_we = 0; b_inc = 1;
    b_tick("w4.sat_inc0", 4'd0, 0, 4'd0, 1);
    b_inc = 0;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/counter_bank.md
COUNTER_BANK -- requirements
Module: counter_bank

Interface
REQ-001 The block SHALL take parameter WIDTH, default 8: counter and limit width in bits (WIDTH >= 1).
REQ-002 The block SHALL take parameter NCH, default 4: number of independent counter channels (NCH >= 1).
REQ-003 The block SHALL take parameter DEFAULT_LIMIT, default 5: limit value loaded at reset (must be < 2**WIDTH).
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 cfg_we  input  1  configuration write strobe.
REQ-007 cfg_limit  input  WIDTH  new shared limit, sampled when cfg_we=1.
REQ-008 cfg_sat  input  1  new mode, sampled when cfg_we=1: 0 = wrap, 1 = saturate.
REQ-009 clr  input  NCH  per-channel synchronous clear.
REQ-010 inc  input  NCH  per-channel increment-by-one request.
REQ-011 dec  input  NCH  per-channel decrement-by-one request.
REQ-012 count  output  NCH*WIDTH  channel i value at bits [i*WIDTH +: WIDTH], registered.
REQ-013 at_limit  output  NCH  combinational: count_i == limit.
REQ-014 wrap  output  NCH  registered one-cycle pulse: channel i wrapped in the previous update.
REQ-015 limit  output  WIDTH  current limit register.
REQ-016 sat_mode  output  1  current mode register.

Function
REQ-017 Every channel SHALL hold count_i in range 0..limit at every cycle.
REQ-018 Per-channel update priority SHALL be: clr, then cfg_we, then inc/dec.
REQ-019 When clr_i=1, count_i SHALL become 0 next cycle and wrap_i SHALL be 0, regardless of other inputs.
REQ-020 When cfg_we=1, limit and sat_mode SHALL load cfg_limit and cfg_sat.
REQ-021 In a cfg_we cycle, inc/dec SHALL be ignored on all channels.
REQ-022 In a cfg_we cycle, any non-cleared count_i > cfg_limit SHALL become cfg_limit.
REQ-023 In a cfg_we cycle, any non-cleared count_i <= cfg_limit SHALL hold, and wrap SHALL be 0 for all channels.
REQ-024 When inc_i=1 and dec_i=1, count_i SHALL hold and wrap_i SHALL be 0.
REQ-025 When inc_i=1 only and count_i < limit, count_i SHALL become count_i+1.
REQ-026 When inc_i=1 only and count_i == limit in wrap mode, count_i SHALL become 0 and wrap_i SHALL pulse.
REQ-027 When inc_i=1 only and count_i == limit in saturate mode, count_i SHALL hold and wrap_i SHALL be 0.
REQ-028 When dec_i=1 only and count_i > 0, count_i SHALL become count_i-1.
REQ-029 When dec_i=1 only and count_i == 0 in wrap mode, count_i SHALL become limit and wrap_i SHALL pulse.
REQ-030 When dec_i=1 only and count_i == 0 in saturate mode, count_i SHALL hold and wrap_i SHALL be 0.
REQ-031 When limit=0, inc/dec in wrap mode SHALL leave count_i at 0 with a wrap_i pulse; in saturate mode they SHALL hold with no pulse.
REQ-032 Increment arithmetic SHALL not overflow: limit = 2**WIDTH-1 wraps to 0 only via REQ-026.
REQ-033 Channels SHALL be fully independent except for the shared limit and sat_mode.
REQ-034 wrap_i SHALL be 0 in any cycle without a qualifying wrap event; pulses SHALL never stretch.
REQ-035 Under `ifdef FORMAL, the RTL SHALL assert count_i <= limit for all i.
REQ-036 Under `ifdef FORMAL, the RTL SHALL assert no wrap pulse follows a clr or cfg_we cycle.

Reset
REQ-037 While rst_n=0, count SHALL be all 0, wrap 0, limit DEFAULT_LIMIT and sat_mode 0, taking effect immediately without a clock edge.
REQ-038 At reset, at_limit SHALL reflect 0 == DEFAULT_LIMIT (all 0 for defaults).
REQ-039 An rst_n assertion mid-operation SHALL discard all pending updates; the first edge after deassertion SHALL apply normal rules.

Verification
REQ-040 Wrap increment: defaults, inc_0=1 for 7 cycles -> count_0 = 1,2,3,4,5,0,1; wrap_0 pulses exactly once, the cycle count_0 shows 0.
REQ-041 Saturate decrement: cfg_we with limit=3, sat=1, then dec_1 at count 0 -> holds 0, no wrap; inc_1 x5 -> 1,2,3,3,3; at_limit_1 high from the third inc.
REQ-042 Clamp on cfg: count_2=5, cfg_we with limit=2 and inc_2=1 -> count_2=2, wrap_2=0, limit=2.
REQ-043 Simultaneous events: clr_3, inc_3 and cfg_we all high -> count_3=0; inc_0 and dec_0 both high -> count_0 unchanged.
REQ-044 Boundary: WIDTH=4, limit=15, wrap mode -> inc at 15 gives 0 with pulse; dec at 0 gives 15 with pulse; limit=0 -> inc gives 0 with pulse.
REQ-045 Async reset: rst_n low between clock edges mid-count -> outputs take their reset values before the next edge.
